// File: rtl/addertree_acc_ctrl.sv
// addertree_acc_ctrl
// Sequences one accumulation job over an external pipelined adder tree.
// A job of num_chunks chunks is requested with a start pulse. Chunks are
// accepted from upstream while in FEED, and each accepted chunk enters the
// tree (tree_issue). A TREE_LATENCY-deep valid shift register follows every
// chunk through the tree. When a chunk's sum appears on tree_sum, it is added
// into a wrapping accumulator. When every chunk has retired, the result is
// held on acc_out/acc_valid until downstream takes it.
//
// Handshakes: a chunk transfers on a cycle where chunk_valid && chunk_ready
// (that cycle is tree_issue). A result transfers on a cycle where
// acc_valid && acc_ready. The side that asserts valid holds its data stable
// until that transfer cycle.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start, num_chunks job request pulse and job length (sampled in IDLE)
//   chunk_valid       upstream chunk present on the tree inputs
//   chunk_ready       controller accepts a chunk (FEED only)
//   tree_issue        chunk enters the adder tree this cycle
//   tree_sum          adder tree output, two's complement
//   acc_out/acc_valid accumulated result and its valid flag
//   acc_ready         downstream accepts the result
//   busy              controller is not IDLE
//   done              1-cycle pulse after the result is taken
//   err_zero          1-cycle pulse after a zero-length start
//   ovf               sticky signed overflow of the running sum
//   stateDbg          current FSM state (IDLE=0, FEED=1, DRAIN=2, OUT=3)
module addertree_acc_ctrl #(
  parameter int NUM_ELEMENTS   = 50,
  parameter int DATA_WIDTH_fix = 64,
  parameter int TREE_LATENCY   = 4,
  parameter int CNT_W          = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [CNT_W-1:0]          num_chunks,
  input  logic                      chunk_valid,
  output logic                      chunk_ready,
  output logic                      tree_issue,
  input  logic [DATA_WIDTH_fix-1:0] tree_sum,
  output logic [DATA_WIDTH_fix-1:0] acc_out,
  output logic                      acc_valid,
  input  logic                      acc_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      err_zero,
  output logic                      ovf,
  output logic [1:0]                stateDbg
);

  // Parameter sanity at elaboration time; NUM_ELEMENTS only describes the
  // tree's chunk size and does not size any logic in this controller.
  if (TREE_LATENCY < 1) begin : gBadLatency
    $error("TREE_LATENCY must be at least 1");
  end
  if (NUM_ELEMENTS < 1) begin : gBadElements
    $error("NUM_ELEMENTS must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam int MSB = DATA_WIDTH_fix - 1;

  state_t                   state, stateNext;
  logic [CNT_W-1:0]         numLatched;
  logic [CNT_W-1:0]         issuedCnt;
  logic [CNT_W-1:0]         retiredCnt;
  logic [CNT_W-1:0]         retiredNext;
  logic [TREE_LATENCY-1:0]  validSr;
  logic [TREE_LATENCY-1:0]  validSrNext;
  logic [DATA_WIDTH_fix-1:0] accReg;
  logic [DATA_WIDTH_fix-1:0] accSum;
  logic                     ovfReg;
  logic                     doneReg;
  logic                     errZeroReg;
  logic                     sumValid;
  logic                     retireEn;
  logic                     acceptStart;
  logic                     lastIssue;
  logic                     addOvf;

  always_comb begin
    chunk_ready = (state == FEED);
    tree_issue  = chunk_valid & chunk_ready;

    // Shifting left and refilling bit 0 also covers TREE_LATENCY == 1.
    validSrNext    = validSr << 1;
    validSrNext[0] = tree_issue;

    sumValid    = validSr[TREE_LATENCY-1];
    retireEn    = sumValid && ((state == FEED) || (state == DRAIN));
    retiredNext = retiredCnt + CNT_W'(retireEn);
    accSum      = accReg + tree_sum;
    // Signed overflow: equal-sign addends producing a result of the other sign.
    addOvf      = (accReg[MSB] == tree_sum[MSB]) && (accSum[MSB] != accReg[MSB]);

    acceptStart = (state == IDLE) && start && (num_chunks != '0);
    lastIssue   = tree_issue && ((issuedCnt + CNT_W'(1)) == numLatched);

    stateNext = state;
    case (state)
      IDLE:  if (acceptStart) stateNext = FEED;
      FEED:  if (lastIssue) stateNext = DRAIN;
      DRAIN: if (retiredNext == numLatched) stateNext = OUT;
      OUT:   if (acc_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      numLatched <= '0;
      issuedCnt  <= '0;
      retiredCnt <= '0;
      validSr    <= '0;
      accReg     <= '0;
      ovfReg     <= 1'b0;
      doneReg    <= 1'b0;
      errZeroReg <= 1'b0;
    end else begin
      state      <= stateNext;
      validSr    <= validSrNext;
      doneReg    <= (state == OUT) && acc_ready;
      errZeroReg <= (state == IDLE) && start && (num_chunks == '0);
      if (acceptStart) begin
        numLatched <= num_chunks;
        issuedCnt  <= '0;
        retiredCnt <= '0;
        accReg     <= '0;
        ovfReg     <= 1'b0;
      end else begin
        if (tree_issue) issuedCnt <= issuedCnt + CNT_W'(1);
        if (retireEn) begin
          retiredCnt <= retiredNext;
          accReg     <= accSum;
          if (addOvf) ovfReg <= 1'b1;
        end
      end
    end
  end

  assign acc_out   = accReg;
  assign acc_valid = (state == OUT);
  assign busy      = (state != IDLE);
  assign done      = doneReg;
  assign err_zero  = errZeroReg;
  assign ovf       = ovfReg;
  assign stateDbg  = state;

endmodule

// File: tb/tb_addertree_acc_ctrl.sv
module tb_addertree_acc_ctrl;
  localparam int L  = 4;
  localparam int W  = 64;
  localparam int CW = 8;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] num_chunks = '0;
  logic          chunk_valid = 1'b0;
  logic          chunk_ready;
  logic          tree_issue;
  logic [W-1:0]  tree_sum = '0;
  logic [W-1:0]  acc_out;
  logic          acc_valid;
  logic          acc_ready = 1'b0;
  logic          busy, done, err_zero, ovf;
  logic [1:0]    state_dbg;

  always #5 clk = ~clk;

  addertree_acc_ctrl #(
    .NUM_ELEMENTS(50), .DATA_WIDTH_fix(W), .TREE_LATENCY(L), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_chunks(num_chunks),
    .chunk_valid(chunk_valid), .chunk_ready(chunk_ready), .tree_issue(tree_issue),
    .tree_sum(tree_sum), .acc_out(acc_out), .acc_valid(acc_valid),
    .acc_ready(acc_ready), .busy(busy), .done(done), .err_zero(err_zero),
    .ovf(ovf), .stateDbg(state_dbg)
  );

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- scoreboard state ----------------
  int           check_cnt = 0;
  int           pass_cnt  = 0;
  logic [W-1:0] exp_q[$];
  logic         exp_ovf_q[$];
  logic [W-1:0] val_q[$];     // chunk sums the tree model will present, in order
  bit           hist_q[$];    // per-cycle issue history for the tree model
  int           last_issue_cyc = 0;
  logic [W-1:0] job_vals[$];  // optional directed chunk values for the next job

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- adder tree model ----------------
  // A chunk issued in cycle c has its sum on tree_sum during cycle c+L.
  // Non-issue slots carry random junk that must never be accumulated.
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      hist_q.delete();
      tree_sum = {$urandom, $urandom};
    end else begin
      hist_q.push_back(tree_issue);
      if (tree_issue) last_issue_cyc = cyc;
      if (hist_q.size() > L) begin
        if (hist_q.pop_front() && val_q.size() > 0) tree_sum = val_q.pop_front();
        else tree_sum = {$urandom, $urandom};
      end else begin
        tree_sum = {$urandom, $urandom};
      end
    end
  end

  // ---------------- monitor ----------------
  logic         prev_valid = 1'b0;
  logic         pend_done  = 1'b0;
  logic [W-1:0] held_out   = '0;
  always @(negedge clk) begin
    #3;
    if (!rst_n) begin
      prev_valid = 1'b0;
      pend_done  = 1'b0;
    end else begin
      if (pend_done) begin
        check("done_pulse", W'(done), W'(1));
        check("idle_after_accept", W'(busy), W'(0));
        pend_done = 1'b0;
      end
      if (acc_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check_cnt++;
          $display("FAIL unexpected_result: got %h expected none", acc_out);
        end else begin
          check("acc_out", acc_out, exp_q.pop_front());
          check("ovf", W'(ovf), W'(exp_ovf_q.pop_front()));
          check("latency", W'(cyc), W'(last_issue_cyc + L + 1));
        end
        held_out = acc_out;
      end else if (acc_valid) begin
        check("hold_stable", acc_out, held_out);
      end
      if (acc_valid && !acc_ready) check("no_early_done", W'(done), W'(0));
      if (acc_valid && acc_ready) pend_done = 1'b1;
      prev_valid = acc_valid;
    end
  end

  // ---------------- driver tasks ----------------
  // Reference: sum modulo 2^W; overflow when any running signed sum leaves
  // the representable range.
  task automatic model_job(input logic [W-1:0] vals[$]);
    logic [W-1:0]        s = '0;
    logic                o = 1'b0;
    logic signed [W:0]   wide;
    foreach (vals[i]) begin
      wide = $signed({s[W-1], s}) + $signed({vals[i][W-1], vals[i]});
      if (wide[W] != wide[W-1]) o = 1'b1;
      s = s + vals[i];
    end
    exp_q.push_back(s);
    exp_ovf_q.push_back(o);
  endtask

  // Called at a negedge. mode: 0 back-to-back, 1 random bubbles, 2 alternating.
  task automatic feed_chunks(input int n, input int mode);
    int sent = 0;
    int guard = 0;
    bit toggle = 1'b1;
    while (sent < n && guard < 300) begin
      case (mode)
        0: chunk_valid = 1'b1;
        1: chunk_valid = 1'($urandom_range(0, 1));
        default: begin chunk_valid = toggle; toggle = ~toggle; end
      endcase
      acc_ready = 1'($urandom_range(0, 1));
      #1;
      if (tree_issue) sent++;
      @(negedge clk);
      guard++;
    end
    chunk_valid = 1'b0;
    acc_ready   = 1'b0;
    if (sent < n) begin
      check_cnt++;
      $display("FAIL feed_timeout: got %0d expected %0d chunks", sent, n);
    end
  endtask

  task automatic run_job(input int n, input int mode, input int hold);
    logic [W-1:0] vals[$];
    int g = 0;
    for (int i = 0; i < n; i++) begin
      if (job_vals.size() > 0) vals.push_back(job_vals.pop_front());
      else if ($urandom_range(0, 3) == 0) vals.push_back({$urandom, $urandom});
      else vals.push_back(W'($urandom_range(0, 1000)));
    end
    model_job(vals);
    foreach (vals[i]) val_q.push_back(vals[i]);
    start = 1'b1;
    num_chunks = CW'(n);
    @(negedge clk);
    start = 1'b0;
    num_chunks = CW'($urandom);
    feed_chunks(n, mode);
    while (!acc_valid && g < 100) begin
      chunk_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      g++;
    end
    chunk_valid = 1'b0;
    if (!acc_valid) begin
      check_cnt++;
      $display("FAIL result_timeout: got acc_valid 0 expected 1");
    end
    for (int h = 0; h < hold; h++) begin
      start = 1'b1;
      num_chunks = CW'($urandom_range(1, 5));
      @(negedge clk);
    end
    start = 1'b0;
    acc_ready = 1'b1;
    @(negedge clk);
    acc_ready = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #1;
    check("rst_acc_valid", W'(acc_valid), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_chunk_ready", W'(chunk_ready), W'(0));
    check("rst_acc_out", acc_out, W'(0));
    check("rst_flags", W'({done, err_zero, ovf, tree_issue}), W'(0));

    // Release and start on the very first edge afterwards.
    @(negedge clk);
    rst_n = 1'b1;
    job_vals = '{W'(64'h10), W'(64'h20), W'(64'h30)};
    run_job(3, 0, 0);

    run_job(2, 2, 0);

    job_vals = '{W'(64'h7FFF_FFFF_FFFF_FFFF), W'(64'h1)};
    run_job(2, 0, 5);

    // Zero-length request.
    start = 1'b1;
    num_chunks = '0;
    @(negedge clk);
    start = 1'b0;
    #3;
    check("err_zero_pulse", W'(err_zero), W'(1));
    check("err_zero_busy", W'(busy), W'(0));
    check("err_zero_chunk_ready", W'(chunk_ready), W'(0));
    @(negedge clk);
    #3;
    check("err_zero_clears", W'(err_zero), W'(0));
    @(negedge clk);

    run_job(4, 1, 2);

    // Reset while draining: job dropped, stale tree output ignored.
    for (int i = 0; i < 3; i++) val_q.push_back({$urandom, $urandom});
    start = 1'b1;
    num_chunks = CW'(3);
    @(negedge clk);
    start = 1'b0;
    feed_chunks(3, 0);
    @(negedge clk);
    check("drain_busy", W'(busy), W'(1));
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", W'({acc_valid, busy, chunk_ready, tree_issue, done, err_zero, ovf}), W'(0));
    check("midrst_acc_out", acc_out, W'(0));
    val_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_job(3, 0, 1);

    for (int j = 0; j < 15; j++) begin
      run_job($urandom_range(1, 8), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    repeat (L + 3) @(negedge clk);
    check("scoreboard_drained", W'(exp_q.size()), W'(0));
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
